// File: rtl/mul_div_unit.sv
// Iterative WIDTH-bit multiply/divide unit holding the architectural HI/LO pair.
// A start in IDLE launches a shift-add multiply or a restoring divide; busy stays high until SIGN writes HI/LO.
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
    return (~v) + {{(WIDTH-1){1'b0}}, 1'b1};
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v);
    return (~v) + {{(2*WIDTH-1){1'b0}}, 1'b1};
  endfunction

  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   opnd_q, opnd_d;
  logic               is_div_q, is_div_d;
  logic               neg_res_q, neg_res_d;
  logic               neg_rem_q, neg_rem_d;
  logic               div0_q, div0_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  logic               signed_op_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH:0]     mul_sum_s;
  logic [WIDTH:0]     div_rsh_s, div_diff_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  assign signed_op_s = ~op[0];
  assign a_mag_s     = (signed_op_s && A[WIDTH-1]) ? neg_w(A) : A;
  assign b_mag_s     = (signed_op_s && B[WIDTH-1]) ? neg_w(B) : B;

  // Multiply step adds the multiplicand into the upper half when the multiplier LSB is set.
  assign mul_sum_s  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                    + (acc_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
  assign div_rsh_s  = acc_q[2*WIDTH-1:WIDTH-1];
  assign div_diff_s = div_rsh_s - {1'b0, opnd_q};

  assign prod_s = neg_res_q ? neg_2w(acc_q) : acc_q;
  assign quo_s  = div0_q ? {WIDTH{1'b1}}
                : (neg_res_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0]);
  assign rem_s  = neg_rem_q ? neg_w(acc_q[2*WIDTH-1:WIDTH]) : acc_q[2*WIDTH-1:WIDTH];

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      acc_q     <= {(2*WIDTH){1'b0}};
      opnd_q    <= {WIDTH{1'b0}};
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (start && !op[2]) begin
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        if (cnt_q == CNT_ZERO) begin
          state_d = S_SIGN;
        end else begin
          state_d = S_CALC;
        end
      end
      S_SIGN:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_q == S_SIGN);
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU: begin
              opnd_d    = a_mag_s;
              acc_d     = {{WIDTH{1'b0}}, b_mag_s};
              is_div_d  = 1'b0;
              neg_res_d = signed_op_s && (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_rem_d = 1'b0;
              div0_d    = 1'b0;
              cnt_d     = CNT_LOAD;
            end
            OP_DIV, OP_DIVU: begin
              opnd_d    = b_mag_s;
              acc_d     = {{WIDTH{1'b0}}, a_mag_s};
              is_div_d  = 1'b1;
              neg_res_d = signed_op_s && (A[WIDTH-1] ^ B[WIDTH-1]);
              neg_rem_d = signed_op_s && A[WIDTH-1];
              div0_d    = (B == {WIDTH{1'b0}});
              cnt_d     = CNT_LOAD;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: begin
              hi_d = hi_q;
            end
          endcase
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_CALC: begin
        // The count-zero cycle only settles, so SIGN closes WIDTH+2 edges after the start.
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
          if (is_div_q) begin
            if (!div_diff_s[WIDTH]) begin
              acc_d = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            end else begin
              acc_d = {div_rsh_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
            end
          end else begin
            acc_d = {mul_sum_s, acc_q[WIDTH-1:1]};
          end
        end else begin
          cnt_d = CNT_ZERO;
        end
      end
      S_SIGN: begin
        if (is_div_q) begin
          hi_d = rem_s;
          lo_d = quo_s;
        end else begin
          hi_d = prod_s[2*WIDTH-1:WIDTH];
          lo_d = prod_s[WIDTH-1:0];
        end
      end
      default: begin
        cnt_d = CNT_ZERO;
      end
    endcase
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed-vector bench for mul_div_unit: results, 34-cycle latency, done pulse, reset abort, MTHI/MTLO.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int nvec;
  int nmis;

  localparam logic [2:0] MULT  = 3'b000;
  localparam logic [2:0] MULTU = 3'b001;
  localparam logic [2:0] DIV   = 3'b010;
  localparam logic [2:0] DIVU  = 3'b011;
  localparam logic [2:0] MTHI  = 3'b100;
  localparam logic [2:0] MTLO  = 3'b101;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nvec++;
    if (obs !== expv) begin
      nmis++;
      $display("FAIL %s: got %h, expected %h", tag, obs, expv);
    end
  endtask

  // Drive start for exactly one rising edge, then return 1 time unit after it.
  task automatic launch(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    start = 1'b1;
    op    = o;
    A     = a;
    B     = b;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until busy drops, then check latency, done pulse and HI/LO.
  task automatic finish_op(input string tag, input int exp_cyc,
                           input logic [31:0] eh, input logic [31:0] el);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val({tag, " cycles"}, 64'(n), 64'(exp_cyc));
    check_val({tag, " done"}, {63'd0, done}, 64'd1);
    check_val({tag, " hi"}, {32'd0, hi}, {32'd0, eh});
    check_val({tag, " lo"}, {32'd0, lo}, {32'd0, el});
  endtask

  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    launch(o, a, b);
    check_val({tag, " busy"}, {63'd0, busy}, 64'd1);
    finish_op(tag, 34, eh, el);
    @(posedge clk);
    #1;
    check_val({tag, " done low"}, {63'd0, done}, 64'd0);
  endtask

  initial begin
    int done_seen;
    nvec  = 0;
    nmis  = 0;
    reset = 1'b1;
    start = 1'b0;
    op    = 3'b000;
    A     = 32'd0;
    B     = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("reset busy", {63'd0, busy}, 64'd0);
    check_val("reset done", {63'd0, done}, 64'd0);
    check_val("reset hilo", {hi, lo}, 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run_op("multu 7*6", MULTU, 32'd7, 32'd6, 32'h0000_0000, 32'd42);
    run_op("mult -1*2", MULT, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    run_op("multu ff*2", MULTU, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult -3*-5", MULT, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0000_0000, 32'd15);
    run_op("div -7/2", DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div 7/-2", DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu 100/7", DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu 100/0", DIVU, 32'd100, 32'd0, 32'd100, 32'hFFFF_FFFF);
    run_op("div -7/0", DIV, 32'hFFFF_FFF9, 32'd0, 32'hFFFF_FFF9, 32'hFFFF_FFFF);
    run_op("div min/-1", DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

    // Reserved opcode leaves everything untouched.
    launch(3'b110, 32'h1111_1111, 32'h2222_2222);
    check_val("op110 busy", {63'd0, busy}, 64'd0);
    check_val("op110 hilo", {hi, lo}, 64'h0000_0000_8000_0000);

    // A start while busy is dropped; the running multiply completes on time.
    launch(MULTU, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    #1;
    launch(DIVU, 32'd9, 32'd3);
    finish_op("busy start", 29, 32'd0, 32'd15);
    @(posedge clk);
    #1;
    check_val("busy start idle", {62'd0, busy, done}, 64'd0);

    // Reset mid-operation aborts without a HI/LO write or done pulse.
    launch(MULTU, 32'd3, 32'd5);
    repeat (4) @(posedge clk);
    #1;
    launch(DIVU, 32'd9, 32'd3);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_val("abort busy", {63'd0, busy}, 64'd0);
    check_val("abort done", {63'd0, done}, 64'd0);
    check_val("abort hilo", {hi, lo}, 64'd0);
    done_seen = 0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) done_seen++;
    end
    check_val("abort quiet", 64'(done_seen), 64'd0);

    launch(MTHI, 32'h1234_5678, 32'd0);
    check_val("mthi hi", {32'd0, hi}, 64'h0000_0000_1234_5678);
    check_val("mthi lo", {32'd0, lo}, 64'd0);
    check_val("mthi busy", {62'd0, busy, done}, 64'd0);
    launch(MTLO, 32'h9ABC_DEF0, 32'd0);
    check_val("mtlo hilo", {hi, lo}, 64'h1234_5678_9ABC_DEF0);
    check_val("mtlo busy", {62'd0, busy, done}, 64'd0);

    // Back-to-back: next start issued in the done cycle.
    launch(MULTU, 32'd1, 32'd1);
    finish_op("multu 1*1", 34, 32'd0, 32'd1);
    launch(MULTU, 32'd3, 32'd5);
    check_val("b2b busy", {63'd0, busy}, 64'd1);
    check_val("b2b done low", {63'd0, done}, 64'd0);
    finish_op("b2b 3*5", 34, 32'd0, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
